piso_tx: RTL and testbench

- Parallel-in serial-out shift transmitter; the transmit end of the serial bit stream that our SISO shift-register chain receives.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on sout, qualified by sout_valid.
- Back-to-back words stream with no idle gap.
- Drives the serial input of downstream SISO/SIPO registers.

---
 rtl/piso_tx.sv | 131 +++++++++++++
 tb/tb_piso_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock. Optional even parity bit: `PISO_PARITY_EN.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             head;
    logic             last_data;
    logic             last;
    logic             handshake;

`ifdef PISO_PARITY_EN
    logic             par;
`endif

    assign head      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign last_data = (state == SHIFT) && (cnt == LAST);

`ifdef PISO_PARITY_EN
    assign last = (state == PARITY);
`else
    assign last = last_data;
`endif

    // Ready only in idle or on the final frame cycle, so a reload there streams gap-free.
    assign load_ready = rst && ((state == IDLE) || last);
    assign handshake  = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_data) begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = handshake ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_next = handshake ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        sout_valid = (state != IDLE);
        busy       = (state != IDLE);
        done       = last;
        sout       = 1'b0;
        case (state)
            SHIFT:   sout = head;
`ifdef PISO_PARITY_EN
            PARITY:  sout = par;
`endif
            default: sout = 1'b0;
        endcase
    end

    // The counter wraps to 0 on the last data bit so it never passes WIDTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (handshake) begin
            shreg <= din;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            cnt <= last_data ? '0 : cnt + CW'(1);
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par <= 1'b0;
        end else if (handshake) begin
            par <= ^din;
        end
    end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus; table
// vectors, a mid-frame reset sequence and random traffic against a frame model.
module tb_piso_tx;

    localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef struct {
        logic             lv;
        logic [WIDTH-1:0] din;
        logic             em;
        logic             el;
        logic             ev;
        logic             ed;
        logic             er;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;

    logic m_ready, m_sout, m_valid, m_busy, m_done;
    logic l_ready, l_sout, l_valid, l_busy, l_done;

    int checks = 0;
    int errors = 0;

    logic             mod_active = 1'b0;
    logic [WIDTH-1:0] mod_word = '0;
    int               mod_pos = 0;

    vec_t vecs[$];

    piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_ready),
        .din(din), .sout(m_sout), .sout_valid(m_valid), .busy(m_busy), .done(m_done)
    );

    piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_ready),
        .din(din), .sout(l_sout), .sout_valid(l_valid), .busy(l_busy), .done(l_done)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic em, input logic el,
                            input logic ev, input logic ed, input logic er);
        check1({tag, " msb sout"}, m_sout, em);
        check1({tag, " msb valid"}, m_valid, ev);
        check1({tag, " msb busy"}, m_busy, ev);
        check1({tag, " msb done"}, m_done, ed);
        check1({tag, " msb ready"}, m_ready, er);
        check1({tag, " lsb sout"}, l_sout, el);
        check1({tag, " lsb valid"}, l_valid, ev);
        check1({tag, " lsb busy"}, l_busy, ev);
        check1({tag, " lsb done"}, l_done, ed);
        check1({tag, " lsb ready"}, l_ready, er);
    endtask

    // Frame-level model: a word plus the position within its frame.
    task automatic checkOutput(input string tag);
        logic em, el, ev, ed, er;
        if (mod_active) begin
            ev = 1'b1;
            ed = (mod_pos == FRAME - 1);
            er = ed;
            if (mod_pos < WIDTH) begin
                em = mod_word[WIDTH-1-mod_pos];
                el = mod_word[mod_pos];
            end else begin
                em = ^mod_word;
                el = ^mod_word;
            end
        end else begin
            ev = 1'b0; ed = 1'b0; er = 1'b1; em = 1'b0; el = 1'b0;
        end
        checkAll(tag, em, el, ev, ed, er);
    endtask

    task automatic modelClock();
        logic hs;
        hs = load_valid && (!mod_active || (mod_pos == FRAME - 1));
        if (hs) begin
            mod_active = 1'b1;
            mod_word   = din;
            mod_pos    = 0;
        end else if (mod_active) begin
            if (mod_pos == FRAME - 1) mod_active = 1'b0;
            else mod_pos++;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelClock();
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        load_valid = v.lv;
        din        = v.din;
        @(negedge clk);
        checkAll($sformatf("vec%0d", idx), v.em, v.el, v.ev, v.ed, v.er);
        @(posedge clk);
        modelClock();
        #1;
    endtask

    task automatic addVec(input logic lv, input logic [WIDTH-1:0] d, input logic em,
                          input logic el, input logic ev, input logic ed, input logic er);
        vec_t v;
        v.lv = lv; v.din = d; v.em = em; v.el = el; v.ev = ev; v.ed = ed; v.er = er;
        vecs.push_back(v);
    endtask

    initial begin
        // Single word 1011, then back-to-back 1100 -> 0011 with load_valid held.
        addVec(1, 4'b1011, 0, 0, 0, 0, 1);
        addVec(0, 4'b0000, 1, 1, 1, 0, 0);
        addVec(0, 4'b0000, 0, 1, 1, 0, 0);
        addVec(0, 4'b0000, 1, 0, 1, 0, 0);
`ifdef PISO_PARITY_EN
        addVec(0, 4'b0000, 1, 1, 1, 0, 0);
        addVec(0, 4'b0000, 1, 1, 1, 1, 1);
`else
        addVec(0, 4'b0000, 1, 1, 1, 1, 1);
`endif
        addVec(0, 4'b0000, 0, 0, 0, 0, 1);
        addVec(1, 4'b1100, 0, 0, 0, 0, 1);
        addVec(1, 4'b0011, 1, 0, 1, 0, 0);
        addVec(1, 4'b0011, 1, 0, 1, 0, 0);
        addVec(1, 4'b0011, 0, 1, 1, 0, 0);
`ifdef PISO_PARITY_EN
        addVec(1, 4'b0011, 0, 1, 1, 0, 0);
        addVec(1, 4'b0011, 0, 0, 1, 1, 1);
`else
        addVec(1, 4'b0011, 0, 1, 1, 1, 1);
`endif
        addVec(0, 4'b0011, 0, 1, 1, 0, 0);
        addVec(0, 4'b0011, 0, 1, 1, 0, 0);
        addVec(0, 4'b0011, 1, 0, 1, 0, 0);
`ifdef PISO_PARITY_EN
        addVec(0, 4'b0011, 1, 0, 1, 0, 0);
        addVec(0, 4'b0011, 0, 0, 1, 1, 1);
`else
        addVec(0, 4'b0011, 1, 0, 1, 1, 1);
`endif
        addVec(0, 4'b0011, 0, 0, 0, 0, 1);

        #3;
        checkAll("in reset", 0, 0, 0, 0, 0);
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i));

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Abort a frame after its second bit; the reset must act without a clock edge.
        load_valid = 1'b1;
        din        = 4'b1011;
        step("mr load");
        load_valid = 1'b0;
        din        = 4'b0000;
        step("mr bit1");
        step("mr bit2");
        #2;
        rst = 1'b0;
        #1;
        checkAll("mr async", 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        checkAll("mr held", 0, 0, 0, 0, 0);
        rst        = 1'b1;
        mod_active = 1'b0;
        mod_pos    = 0;
        load_valid = 1'b1;
        din        = 4'b0110;
        step("mr reload");
        load_valid = 1'b0;
        for (int i = 0; i < FRAME + 1; i++) step($sformatf("mr frame%0d", i));

        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(3) != 0);
            din        = WIDTH'($urandom);
            step($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
